gpio_in_conditioner: RTL and testbench



---
 rtl/gpio_in_pkg.sv | 15 +
 rtl/gpio_debounce_chan.sv | 120 ++++++++++++
 rtl/gpio_in_conditioner.sv | 57 +++++
 tb/tb_gpio_in_conditioner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// Shared types for the GPIO input conditioner: debounce FSM states and default timing.
// Latency/backpressure: none (types and constants only).
package gpio_in_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } debounce_state_e;

  // 10 ms of stability at a 50 MHz system clock.
  localparam int unsigned DefaultDebounceCycles50MHz = 500000;

endpackage

// File: rtl/gpio_debounce_chan.sv
// One input channel: pad synchroniser, polarity fix, debounce FSM, edge pulses and sticky event.
// Latency SyncStages+DebounceCycles edges from pad sample to gp_o; no backpressure (free-running).
module gpio_debounce_chan
  import gpio_in_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = DefaultDebounceCycles50MHz,
  parameter bit          InvertBit      = 1'b0,
  parameter bit          ResetBit       = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic raw_i,
  input  logic event_clr_i,
  output logic gp_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam debounce_state_e ResetState = ResetBit ? STABLE_HI : STABLE_LO;
  // Idle pads must look like the reset level after inversion, so no edge follows reset release.
  localparam logic [SyncStages-1:0] SyncReset = {SyncStages{ResetBit ^ InvertBit}};

  logic [SyncStages-1:0] sync_q, sync_d;
  debounce_state_e       state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  gp_q, gp_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  event_q, event_d;
  logic                  s;

  assign sync_d = {sync_q[SyncStages-2:0], raw_i};
  assign s      = sync_q[SyncStages-1] ^ InvertBit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gp_d    = gp_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    event_d = event_q & ~event_clr_i;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CntOne;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = STABLE_HI;
          gp_d    = 1'b1;
          rise_d  = 1'b1;
          event_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CntOne;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = STABLE_LO;
          gp_d    = 1'b0;
          fall_d  = 1'b1;
          event_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = ResetState;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q  <= SyncReset;
      state_q <= ResetState;
      cnt_q   <= '0;
      gp_q    <= ResetBit;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gp_q    <= gp_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign gp_o    = gp_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions Width pad inputs into a debounced GPIO bus with edge pulses, sticky events and an irq.
// Latency SyncStages+DebounceCycles edges to gp_o, irq_o one more; no backpressure.
module gpio_in_conditioner
  import gpio_in_pkg::*;
#(
  parameter int unsigned     Width          = 15,
  parameter int unsigned     SyncStages     = 2,
  parameter int unsigned     DebounceCycles = DefaultDebounceCycles50MHz,
  parameter logic [Width-1:0] InvertMask    = '0,
  parameter logic [Width-1:0] ResetValue    = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  input  logic [Width-1:0] event_clr_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] event_o,
  output logic             irq_o
);

  logic irq_q, irq_d;

  for (genvar i = 0; i < Width; i++) begin : g_chan
    gpio_debounce_chan #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .InvertBit     (InvertMask[i]),
      .ResetBit      (ResetValue[i])
    ) u_chan (
      .clk_sys_i  (clk_sys_i),
      .rst_sys_ni (rst_sys_ni),
      .raw_i      (raw_i[i]),
      .event_clr_i(event_clr_i[i]),
      .gp_o       (gp_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .event_o    (event_o[i])
    );
  end

  always_comb begin
    irq_d = |event_o;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Randomised and directed bench for gpio_in_conditioner against a run-length behavioural model.
module tb_gpio_in_conditioner;

  localparam int         W   = 4;
  localparam int         SS  = 2;
  localparam int         D   = 4;
  localparam logic [3:0] INV = 4'b1000;
  localparam logic [3:0] RV  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw, clr;
  logic [3:0] gp, rise, fall, evt;
  logic       irq;

  gpio_in_conditioner #(
    .Width(W), .SyncStages(SS), .DebounceCycles(D), .InvertMask(INV), .ResetValue(RV)
  ) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw), .event_clr_i(clr),
    .gp_o(gp), .rise_o(rise), .fall_o(fall), .event_o(evt), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: pad samples delayed SS edges, then a level must differ from gp for D+1 sampled edges.
  logic [3:0] m_sh [SS];
  int         m_run [4];
  logic [3:0] m_gp, m_rise, m_fall, m_evt, m_s;
  logic       m_irq;
  int         rise_cnt [4];
  int         fall_cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    rst_n = 1'b0;
    raw   = 4'b0000;
    clr   = 4'b0000;

    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          for (int k = 0; k < SS; k++) m_sh[k] = RV ^ INV;
          for (int i = 0; i < 4; i++) m_run[i] = 0;
          m_gp = RV; m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
        end else begin
          m_s   = m_sh[SS-1] ^ INV;
          m_irq = |m_evt;
          m_rise = '0;
          m_fall = '0;
          for (int i = 0; i < 4; i++) begin
            if (m_s[i] != m_gp[i]) begin
              m_run[i]++;
              if (m_run[i] == D + 1) begin
                m_gp[i]   = m_s[i];
                m_rise[i] = m_s[i];
                m_fall[i] = ~m_s[i];
                m_run[i]  = 0;
              end
            end else begin
              m_run[i] = 0;
            end
            if (m_rise[i] || m_fall[i]) m_evt[i] = 1'b1;
            else if (clr[i])            m_evt[i] = 1'b0;
          end
          for (int k = SS - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
          m_sh[0] = raw;
        end
      end
      forever begin
        @(negedge clk);
        chk("gp_o", 32'(gp), 32'(m_gp));
        chk("rise_o", 32'(rise), 32'(m_rise));
        chk("fall_o", 32'(fall), 32'(m_fall));
        chk("event_o", 32'(evt), 32'(m_evt));
        chk("irq_o", 32'(irq), 32'(m_irq));
        chk("rise_and_fall", 32'(rise & fall), 32'(0));
        for (int i = 0; i < 4; i++) begin
          if (rise[i]) rise_cnt[i]++;
          if (fall[i]) fall_cnt[i]++;
        end
      end
    join_none

    #23 rst_n = 1'b1;
    step(20);
    chk("idle_gp", 32'(gp), 32'(4'b1000));
    chk("idle_event", 32'(evt), 32'(0));
    chk("idle_irq", 32'(irq), 32'(0));
    chk("idle_pulses", 32'(rise_cnt[0] + rise_cnt[3] + fall_cnt[0] + fall_cnt[3]), 32'(0));

    // ch0 rise: sampled on the next edge, committed SS+D edges later.
    raw[0] = 1'b1;
    step(6);
    chk("ch0_before_commit", 32'(gp[0]), 32'(0));
    step(1);
    chk("ch0_commit_gp", 32'(gp[0]), 32'(1));
    chk("ch0_commit_rise", 32'(rise[0]), 32'(1));
    chk("ch0_commit_event", 32'(evt[0]), 32'(1));
    chk("ch0_commit_irq", 32'(irq), 32'(0));
    step(1);
    chk("ch0_rise_done", 32'(rise[0]), 32'(0));
    chk("ch0_irq_late", 32'(irq), 32'(1));

    // ch1 short glitch is filtered.
    raw[1] = 1'b1;
    step(3);
    raw[1] = 1'b0;
    step(10);
    chk("ch1_gp", 32'(gp[1]), 32'(0));
    chk("ch1_event", 32'(evt[1]), 32'(0));
    chk("ch1_rises", 32'(rise_cnt[1]), 32'(0));

    // ch2 chatter then hold.
    raw[2] = 1'b1; step(1);
    raw[2] = 1'b0; step(1);
    raw[2] = 1'b1; step(1);
    raw[2] = 1'b0; step(1);
    raw[2] = 1'b1;
    step(6);
    chk("ch2_before_commit", 32'(gp[2]), 32'(0));
    step(1);
    chk("ch2_commit_gp", 32'(gp[2]), 32'(1));
    chk("ch2_commit_rise", 32'(rise[2]), 32'(1));
    step(5);
    chk("ch2_one_rise", 32'(rise_cnt[2]), 32'(1));
    clr = 4'b0100;
    step(1);
    clr = 4'b0000;
    chk("ch2_cleared", 32'(evt[2]), 32'(0));

    // ch0 fall with a clear on the commit edge: set wins.
    raw[0] = 1'b0;
    step(6);
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    chk("ch0_fall_pulse", 32'(fall[0]), 32'(1));
    chk("ch0_set_wins", 32'(evt[0]), 32'(1));
    step(3);
    chk("ch0_event_held", 32'(evt[0]), 32'(1));
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    chk("ch0_lone_clear", 32'(evt), 32'(0));
    chk("irq_lags_clear", 32'(irq), 32'(1));
    step(1);
    chk("irq_dropped", 32'(irq), 32'(0));

    // ch3 (inverted) reset during its debounce wait.
    raw[3] = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("async_gp", 32'(gp), 32'(4'b1000));
    chk("async_pulses", 32'(rise | fall), 32'(0));
    chk("async_event", 32'(evt), 32'(0));
    chk("async_irq", 32'(irq), 32'(0));
    raw = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(12);
    chk("ch3_gp_kept", 32'(gp[3]), 32'(1));
    chk("ch3_no_fall", 32'(fall_cnt[3]), 32'(0));

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) raw[i] = ~raw[i];
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
